// File: rtl/median2x2_stream_filter_if.sv
// Pixel stream bundle for the 2x2 median filter: input stream towards the
// filter and output stream towards the sink, each with valid/ready.
interface median2x2_stream_filter_if #(
    parameter int PIX_W = 24
) ();
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_pixel;
    logic             out_last;

    // Source/sink side (drives input pixels, accepts output pixels)
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_last
    );

    // Filter side
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_last
    );
endinterface

// File: rtl/median2x2_stream_filter.sv
// Streaming 2x2 median filter: one raster frame of NUM_CH-channel pixels,
// one-line buffer, per-channel rounded mean of the two middle values of
// every fully populated 2x2 window, valid/ready on both sides.
module median2x2_stream_filter #(
    parameter int IMG_W    = 1080,
    parameter int IMG_H    = 720,
    parameter int CH_W     = 8,
    parameter int NUM_CH   = 3,
    parameter int ROUND_UP = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    median2x2_stream_filter_if.slave    px,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int PIX_W = NUM_CH * CH_W;
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             in_ready_w;
    logic             in_xfer;
    logic             out_xfer;
    logic             at_last;
    logic             emit;

    logic [PIX_W-1:0] line_mem [IMG_W];
    logic [PIX_W-1:0] above;
    // Left column of the window: loaded from the right column of the
    // previous transfer, so only the left pair needs storage.
    logic [PIX_W-1:0] top_l_q;
    logic [PIX_W-1:0] bot_l_q;
    logic [PIX_W-1:0] med;

    logic             out_valid_q;
    logic [PIX_W-1:0] out_pixel_q;
    logic             out_last_q;

    // Per channel: (sum of four - max - min) / 2 with optional round-up
    function automatic logic [PIX_W-1:0] mid_mean(
        input logic [PIX_W-1:0] a, b, c, d
    );
        logic [PIX_W-1:0] res;
        logic [CH_W-1:0]  va, vb, vc, vd;
        logic [CH_W-1:0]  mx_ab, mx_cd, mn_ab, mn_cd, mx, mn;
        logic [CH_W+1:0]  sum4;
        logic [CH_W:0]    mid;
        logic [CH_W:0]    rnd;
        res = '0;
        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            va    = a[ch*CH_W +: CH_W];
            vb    = b[ch*CH_W +: CH_W];
            vc    = c[ch*CH_W +: CH_W];
            vd    = d[ch*CH_W +: CH_W];
            mx_ab = (va > vb) ? va : vb;
            mn_ab = (va > vb) ? vb : va;
            mx_cd = (vc > vd) ? vc : vd;
            mn_cd = (vc > vd) ? vd : vc;
            mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
            mn    = (mn_ab < mn_cd) ? mn_ab : mn_cd;
            sum4  = {2'b00, va} + {2'b00, vb} + {2'b00, vc} + {2'b00, vd};
            mid   = (CH_W+1)'(sum4 - {2'b00, mx} - {2'b00, mn});
            rnd   = mid + (CH_W+1)'(ROUND_UP != 0);
            res[ch*CH_W +: CH_W] = CH_W'(rnd >> 1);
        end
        return res;
    endfunction

    assign in_ready_w = (state_q == RUN) && (!out_valid_q || px.out_ready);
    assign in_xfer    = px.in_valid && in_ready_w;
    assign out_xfer   = out_valid_q && px.out_ready;
    assign at_last    = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign emit       = in_xfer && (x_q != '0) && (y_q != '0);
    assign above      = line_mem[x_q];
    assign med        = mid_mean(top_l_q, above, bot_l_q, px.in_pixel);

    assign px.in_ready  = in_ready_w;
    assign px.out_valid = out_valid_q;
    assign px.out_pixel = out_pixel_q;
    assign px.out_last  = out_last_q;
    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);

    // Next state and raster coordinates
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            RUN: begin
                if (in_xfer) begin
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = (y_q == YW'(IMG_H - 1)) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (at_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_xfer && out_last_q) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and coordinate registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Line buffer (read-before-write at column x) and window left column
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            line_mem[x_q] <= px.in_pixel;
            top_l_q       <= above;
            bot_l_q       <= px.in_pixel;
        end
    end

    // Registered output stage; held while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= med;
            out_last_q  <= at_last;
        end else if (px.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end
endmodule
